dglk_playback_seq: RTL

Parametrised sample-playback engine for the DgLk digital-lock datapath; successor to the single-mode free-running playback buffer. Samples are loaded into an internal block RAM and replayed on a fixed-latency registered output in one of three modes: one-shot, loop, or stream (circular FIFO with underrun/overflow detection). Each sample is held for a programmable number of cycles. It sits between the sequencer's write strobes and the DAC/modulation path.

---
 rtl/dglk_playback_seq_if.sv | 44 ++++
 rtl/dglk_playback_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dglk_playback_seq_if.sv
// Bus bundle for dglk_playback_seq.
// The master side (sequencer) drives the write, clear, mode, start/stop and hold
// controls. The slave side (playback engine) returns the playback sample, its
// valid flag, busy/done status, fill level and the sticky underrun/overflow flags.
//   wr_stb/wr_data : store one sample at the write pointer
//   wr_clr         : clear pointers, level and flags; abort playback
//   mode           : 00 one-shot, 01 loop, 10 stream, 11 behaves as one-shot
//   start/stop     : single-cycle playback control pulses
//   hold           : each sample is presented hold+1 cycles
//   pbk_out/vld    : registered playback sample and its valid flag
//   busy/done      : engine running / one-shot completion pulse
//   level          : stored (stream: unread) sample count
//   underrun       : stream ran dry (sticky until wr_clr)
//   overflow       : a write was dropped on a full buffer (sticky until wr_clr)
interface dglk_playback_seq_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10,
    parameter int unsigned HW = 8
);
    logic          wr_stb;
    logic [DW-1:0] wr_data;
    logic          wr_clr;
    logic [1:0]    mode;
    logic          start;
    logic          stop;
    logic [HW-1:0] hold;
    logic [DW-1:0] pbk_out;
    logic          pbk_vld;
    logic          busy;
    logic          done;
    logic [AW:0]   level;
    logic          underrun;
    logic          overflow;

    modport master (
        output wr_stb, wr_data, wr_clr, mode, start, stop, hold,
        input  pbk_out, pbk_vld, busy, done, level, underrun, overflow
    );

    modport slave (
        input  wr_stb, wr_data, wr_clr, mode, start, stop, hold,
        output pbk_out, pbk_vld, busy, done, level, underrun, overflow
    );
endinterface

// File: rtl/dglk_playback_seq.sv
// Sample-playback engine for the DgLk digital-lock datapath.
// Samples are written into a simple dual-port RAM and replayed in one-shot, loop
// or stream (circular FIFO) mode with a fixed two-cycle read latency from the read
// pointer to pbk_out. Every sample is held for hold+1 cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dglk_playback_seq_if slave modport (controls in, playback/status out)
module dglk_playback_seq #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10,
    parameter int unsigned HW = 8
) (
    input logic                clk,
    input logic                rst_n,
    dglk_playback_seq_if.slave bus
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW:0] Full  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};
    localparam logic [HW-1:0] HoldOne = {{(HW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {
        ModeOneShot = 2'b00,
        ModeLoop    = 2'b01,
        ModeStream  = 2'b10
    } mode_e;

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [AW:0]   w_ptr_q, w_ptr_d;
    logic [AW:0]   r_ptr_q, r_ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          vld1_q, pbk_vld_q;
    logic [DW-1:0] pbk_out_q;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [Depth];

    logic [AW:0]   level;
    logic [AW:0]   r_nxt;
    logic          is_last;
    logic          full;
    logic          wr_en;
    logic          issue;
    logic          flush;
    logic          start_ok;

    // Stream level counts unread samples; otherwise the whole written region.
    assign level   = (mode_q == ModeStream) ? (w_ptr_q - r_ptr_q) : w_ptr_q;
    assign full    = (level == Full);
    assign r_nxt   = r_ptr_q + PtrOne;
    assign is_last = (r_nxt == w_ptr_q);
    assign wr_en   = bus.wr_stb && !bus.wr_clr && !full;

    // One-shot/loop restart from index 0, so only the write pointer matters there.
    assign start_ok = bus.start && !bus.stop &&
                      ((bus.mode == ModeStream) || (w_ptr_q != '0));

    // The read address is live in RUN, except when a stream has nothing unread.
    assign issue = (state_q == StRun) && ((mode_q != ModeStream) || (level != '0));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        w_ptr_d    = w_ptr_q;
        r_ptr_d    = r_ptr_q;
        hold_cnt_d = hold_cnt_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        flush      = 1'b0;

        if (bus.wr_clr) begin
            w_ptr_d    = '0;
            r_ptr_d    = '0;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
            state_d    = StIdle;
            flush      = 1'b1;
        end else begin
            if (bus.wr_stb) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    w_ptr_d = w_ptr_q + PtrOne;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_d    = StRun;
                        hold_cnt_d = bus.hold;
                        unique case (bus.mode)
                            2'b01:   mode_d = ModeLoop;
                            2'b10:   mode_d = ModeStream;
                            default: mode_d = ModeOneShot;
                        endcase
                        if (bus.mode != ModeStream) begin
                            r_ptr_d = '0;
                        end
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state_d = StIdle;
                        flush   = 1'b1;
                    end else if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HoldOne;
                    end else begin
                        hold_cnt_d = bus.hold;
                        unique case (mode_q)
                            ModeLoop: begin
                                r_ptr_d = is_last ? '0 : r_nxt;
                            end
                            ModeStream: begin
                                // Nothing unread: park the pointer and flag it.
                                if (level == '0) begin
                                    underrun_d = 1'b1;
                                end else begin
                                    r_ptr_d = r_nxt;
                                end
                            end
                            default: begin
                                if (is_last) begin
                                    state_d = StIdle;
                                    done_d  = 1'b1;
                                end else begin
                                    r_ptr_d = r_nxt;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= ModeOneShot;
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            hold_cnt_q <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Sample storage: contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr_q[AW-1:0]] <= bus.wr_data;
        end
        ram_q <= mem[r_ptr_q[AW-1:0]];
    end

    // Valid follows the RAM read by two stages; stop/clear discards in-flight reads
    // while pbk_out keeps the last presented sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q    <= 1'b0;
            pbk_vld_q <= 1'b0;
            pbk_out_q <= '0;
        end else if (flush) begin
            vld1_q    <= 1'b0;
            pbk_vld_q <= 1'b0;
        end else begin
            vld1_q    <= issue;
            pbk_vld_q <= vld1_q;
            if (vld1_q) begin
                pbk_out_q <= ram_q;
            end
        end
    end

    assign bus.pbk_out  = pbk_out_q;
    assign bus.pbk_vld  = pbk_vld_q;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = done_q;
    assign bus.level    = level;
    assign bus.underrun = underrun_q;
    assign bus.overflow = overflow_q;

endmodule
